// File: rtl/hash_target_checker.sv
// Multi-lane SHA-256d target checker: compares LANES byte-reversed hashes per
// beat against a compact-encoded target, tracks first winning nonce, hit count.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   valid_i, newblock_i beat qualifier / first beat of a block (loads difficulty_i)
//   hash_i              LANES x 256-bit hashes, lane k at [256k+255:256k]
//   nonce_i             nonce of lane 0 (lane k uses nonce_i + k)
//   difficulty_i        compact target {exp[7:0], mantissa[23:0]}
//   valid_o, newblock_o valid_i / newblock_i delayed STAGES cycles
//   hit_o               per-lane hash <= target, qualified by valid_o
//   found_o             a hit occurred in the current block (sticky)
//   found_nonce_o       nonce of the first hit in the current block
//   hit_count_o         saturating hit count for the current block
//   bad_difficulty_o    latched difficulty word is malformed
module hash_target_checker #(
    parameter int LANES   = 4,
    parameter int STAGES  = 2,
    parameter int NONCE_W = 32,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    input  logic                   newblock_i,
    input  logic [256*LANES-1:0]   hash_i,
    input  logic [NONCE_W-1:0]     nonce_i,
    input  logic [31:0]            difficulty_i,
    output logic                   valid_o,
    output logic                   newblock_o,
    output logic [LANES-1:0]       hit_o,
    output logic                   found_o,
    output logic [NONCE_W-1:0]     found_nonce_o,
    output logic [CNT_W-1:0]       hit_count_o,
    output logic                   bad_difficulty_o
);

    // ------------------------------------------------------------------
    // Compact difficulty expansion
    // ------------------------------------------------------------------
    logic [7:0]   exp_w;
    logic [23:0]  mant_w;
    logic [255:0] new_tgt;
    logic         new_bad;

    always_comb begin
        exp_w   = difficulty_i[31:24];
        mant_w  = difficulty_i[23:0];
        new_tgt = '0;
        new_bad = mant_w[23] | (exp_w > 8'd32);
        case (exp_w)
            8'd0: begin
                new_tgt = '0;
                new_bad = new_bad | (|mant_w);
            end
            8'd1: begin
                new_tgt = {248'b0, mant_w[23:16]};
                new_bad = new_bad | (|mant_w[15:0]);
            end
            8'd2: begin
                new_tgt = {240'b0, mant_w[23:8]};
                new_bad = new_bad | (|mant_w[7:0]);
            end
            default: begin
                // exp in 3..32 cannot overflow 256 bits; larger exps are bad
                new_tgt = {232'b0, mant_w} << ({exp_w[5:0], 3'b000} - 9'd24);
            end
        endcase
        if (new_bad) begin
            new_tgt = '0;
        end
    end

    // ------------------------------------------------------------------
    // Held target; a newblock beat uses the freshly expanded value
    // ------------------------------------------------------------------
    logic [255:0] tgt_q, tgt_d;
    logic         tgt_bad_q, tgt_bad_d;
    logic [255:0] cur_tgt;
    logic         cur_bad;

    always_comb begin
        tgt_d     = newblock_i ? new_tgt : tgt_q;
        tgt_bad_d = newblock_i ? new_bad : tgt_bad_q;
        cur_tgt   = tgt_d;
        cur_bad   = tgt_bad_d;
    end

    // ------------------------------------------------------------------
    // Lane compare (full compare in the first stage, later stages delay)
    // ------------------------------------------------------------------
    logic [LANES-1:0] hit_in;
    logic [255:0]     num;

    always_comb begin
        hit_in = '0;
        num    = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int i = 0; i < 32; i++) begin
                num[8*i +: 8] = hash_i[256*k + 255 - 8*i -: 8];
            end
            hit_in[k] = valid_i & ~cur_bad & (num <= cur_tgt);
        end
    end

    // ------------------------------------------------------------------
    // Delay pipeline
    // ------------------------------------------------------------------
    logic [STAGES-1:0]  v_q, v_d;
    logic [STAGES-1:0]  nb_q, nb_d;
    logic [STAGES-1:0]  badp_q, badp_d;
    logic [LANES-1:0]   hitp_q   [STAGES];
    logic [LANES-1:0]   hitp_d   [STAGES];
    logic [NONCE_W-1:0] noncep_q [STAGES];
    logic [NONCE_W-1:0] noncep_d [STAGES];

    always_comb begin
        v_d[0]      = valid_i;
        nb_d[0]     = newblock_i;
        badp_d[0]   = cur_bad;
        hitp_d[0]   = hit_in;
        noncep_d[0] = nonce_i;
        for (int s = 1; s < STAGES; s++) begin
            v_d[s]      = v_q[s-1];
            nb_d[s]     = nb_q[s-1];
            badp_d[s]   = badp_q[s-1];
            hitp_d[s]   = hitp_q[s-1];
            noncep_d[s] = noncep_q[s-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q       <= '0;
            nb_q      <= '0;
            badp_q    <= '0;
            tgt_q     <= '0;
            tgt_bad_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                hitp_q[s]   <= '0;
                noncep_q[s] <= '0;
            end
        end else begin
            v_q       <= v_d;
            nb_q      <= nb_d;
            badp_q    <= badp_d;
            tgt_q     <= tgt_d;
            tgt_bad_q <= tgt_bad_d;
            for (int s = 0; s < STAGES; s++) begin
                hitp_q[s]   <= hitp_d[s];
                noncep_q[s] <= noncep_d[s];
            end
        end
    end

    logic [NONCE_W-1:0] nonce_out;

    assign valid_o    = v_q[STAGES-1];
    assign newblock_o = nb_q[STAGES-1];
    assign hit_o      = hitp_q[STAGES-1] & {LANES{valid_o}};
    assign nonce_out  = noncep_q[STAGES-1];

    // ------------------------------------------------------------------
    // Per-block bookkeeping at the output side
    // ------------------------------------------------------------------
    logic               found_q, found_d;
    logic [NONCE_W-1:0] fnonce_q, fnonce_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bad_q, bad_d;
    logic [7:0]         pop;
    logic [NONCE_W-1:0] low_idx;
    logic [CNT_W+7:0]   sum;

    always_comb begin
        found_d  = found_q;
        fnonce_d = fnonce_q;
        cnt_d    = cnt_q;
        bad_d    = bad_q;
        pop      = '0;
        low_idx  = '0;
        sum      = '0;
        if (newblock_o) begin
            found_d  = 1'b0;
            fnonce_d = '0;
            cnt_d    = '0;
            bad_d    = badp_q[STAGES-1];
        end
        for (int k = LANES - 1; k >= 0; k--) begin
            pop = pop + {7'b0, hit_o[k]};
            if (hit_o[k]) begin
                low_idx = NONCE_W'(k);
            end
        end
        if (|hit_o && !found_d) begin
            found_d  = 1'b1;
            fnonce_d = nonce_out + low_idx;
        end
        sum = {8'b0, cnt_d} + {{CNT_W{1'b0}}, pop};
        if (sum > {8'b0, {CNT_W{1'b1}}}) begin
            cnt_d = {CNT_W{1'b1}};
        end else begin
            cnt_d = sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            found_q  <= 1'b0;
            fnonce_q <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
        end else begin
            found_q  <= found_d;
            fnonce_q <= fnonce_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
        end
    end

    assign found_o          = found_q;
    assign found_nonce_o    = fnonce_q;
    assign hit_count_o      = cnt_q;
    // New block's flag shows alongside newblock_o, then is held
    assign bad_difficulty_o = newblock_o ? badp_q[STAGES-1] : bad_q;

endmodule

// File: doc/hash_target_checker.md
Name: hash_target_checker

Overview:
Multi-lane, pipelined successor to the single-hash final validator. It sits after the final SHA-256d stage and compares LANES double-hashes per beat against the target expanded from a compact difficulty word. It reports a per-lane hit mask and captures the first winning nonce of each block. It also keeps a saturating per-block hit count and flags malformed difficulty words.

Parameters:
LANES, 4, number of hashes presented per beat; lane k carries nonce nonce_i+k
STAGES, 2, compare pipeline depth in cycles (1..4); equals valid_i-to-valid_o latency
NONCE_W, 32, nonce width
CNT_W, 16, hit counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
valid_i  in  1  beat qualifier
newblock_i  in  1  first beat of a new block; latches difficulty_i
hash_i  in  256*LANES  lane k at [256k+255:256k]; byte 0 of each lane is the most significant numeric byte
nonce_i  in  NONCE_W  nonce of lane 0
difficulty_i  in  32  compact target: exp=[31:24], mantissa=[23:0]
valid_o  out  1  valid_i delayed STAGES
newblock_o  out  1  newblock_i delayed STAGES
hit_o  out  LANES  per-lane hash<=target, qualified by valid_o
found_o  out  1  sticky: a hit occurred in the current block
found_nonce_o  out  NONCE_W  nonce of the first hit in the current block
hit_count_o  out  CNT_W  hits in the current block, saturating
bad_difficulty_o  out  1  latched difficulty is malformed

Behaviour:
- Reset (async, active-high): every output 0, target register 0, pipeline valids/newblocks cleared. Reset mid-operation discards in-flight beats.
- Hash numeric value: byte-reverse each lane. Numeric bits [8i+7:8i] = hash lane bits [255-8i:248-8i].
- Target expansion, 256-bit unsigned:
  - exp>=3: mantissa << 8*(exp-3).
  - exp<3: mantissa >> 8*(3-exp).
- Malformed difficulty, giving target 0 and bad=1:
  - mantissa[23]=1 (negative), or
  - exp>32, or
  - shifted-out nonzero bits.
- Target register loads on newblock_i (regardless of valid_i). bad_difficulty_o follows the register; it is aligned to newblock_o.
- A beat with newblock_i=1 compares against the newly supplied difficulty_i, not the held target.
- Compare: lane hit = numeric<=target, evaluated over STAGES cycles; partitioning of the 256-bit compare across stages is free. hit_o=0 whenever valid_o=0.
- valid_o, newblock_o and hit_o are aligned; latency is exactly STAGES; full throughput of 1 beat/cycle, no backpressure.
- Per-block state updates at the output side, on valid_o or newblock_o:
  - newblock_o=1: clear found_o, found_nonce_o and hit_count_o. The same beat's hits then count toward the new block.
  - First beat with |hit_o and found_o=0: found_o<=1; found_nonce_o<=beat nonce + index of the lowest hitting lane.
  - Later hits do not change found_nonce_o.
  - hit_count_o += popcount(hit_o), saturating at 2^CNT_W-1.
- Nonce addition wraps modulo 2^NONCE_W.
- newblock_i without valid_i: clears state and reloads the target; no hits are produced.

Test Plan:
- Reset: assert rst mid-stream with beats in flight -> all outputs 0 immediately; no valid_o emerges from pre-reset beats.
- Target boundary: difficulty 0x1d00ffff (target 0xffff<<208), lane0 numeric value exactly equal to target, lane1 equal to target+1 -> after STAGES cycles hit_o=4'b0001, found_nonce_o=nonce_i.
- First-hit capture: newblock beat nonce 0x100 with no hits, then a beat nonce 0x104 with lanes 2,3 hitting, then nonce 0x108 with lane0 hitting -> found_nonce_o=0x106, hit_count_o=3, found_o held.
- Block change: newblock_i with difficulty 0x03000001 on the same beat as a lane hashing to numeric 1 -> old found cleared; hit on that beat, found_nonce_o = that lane's nonce, hit_count_o=1.
- Malformed difficulty: 0x21000001, 0x1d800000 and 0x01000100 -> bad_difficulty_o=1 and hit_o=0 even for an all-zero hash; 0x02008000 -> target 0x80, bad=0.
- Saturation/wrap: CNT_W=4, 5 beats all lanes hitting -> hit_count_o=15; nonce_i=0xFFFFFFFE with lane 3 first hit -> found_nonce_o=0x00000001.
